// File: rtl/pad_in_filter.sv
// pad_in_filter: multi-channel pad conditioner for board inputs.
// Each channel has a reset-time pull level, a synchroniser, optional
// inversion, a tick-driven debounce filter and registered rise/fall pulses.
module pad_in_filter #(
  parameter int unsigned    NCH         = 4,
  parameter int unsigned    CNT_W       = 16,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [NCH-1:0] PULL_VAL    = {NCH{1'b1}},
  parameter logic [NCH-1:0] INV_MASK    = {NCH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [NCH-1:0]   pad_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic [NCH-1:0]   chan_en_i,
  output logic [NCH-1:0]   level_o,
  output logic [NCH-1:0]   rise_o,
  output logic [NCH-1:0]   fall_o
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [NCH-1:0]   sync_r [SYNC_STAGES];
  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   differ_s;
  logic [CNT_W:0]   thr_ext_s;
  logic [CNT_W-1:0] base_s [NCH];
  logic [CNT_W:0]   cnt_inc_s [NCH];

  state_t           state_r [NCH];
  state_t           state_s [NCH];
  logic [CNT_W-1:0] cnt_r [NCH];
  logic [CNT_W-1:0] cnt_s [NCH];
  logic [NCH-1:0]   level_r, level_s;
  logic [NCH-1:0]   rise_r, rise_s;
  logic [NCH-1:0]   fall_r, fall_s;

  // Logical level seen by the filter: synchroniser output with per-channel polarity fix.
  assign raw_s     = sync_r[SYNC_STAGES-1] ^ INV_MASK;
  assign differ_s  = raw_s ^ level_r;
  assign thr_ext_s = {1'b0, threshold_i};

  // Synchroniser chain; reset loads the pull level so nothing toggles out of reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= PULL_VAL;
      end
    end else begin
      sync_r[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Per-channel debounce next-state: counts ticks while raw differs, commits on threshold.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_s[c] = state_r[c];
      cnt_s[c]   = cnt_r[c];
      level_s[c] = level_r[c];
      rise_s[c]  = 1'b0;
      fall_s[c]  = 1'b0;

      // A channel leaving STABLE starts from zero, so the first tick may land this cycle.
      case (state_r[c])
        ST_STABLE:   base_s[c] = {CNT_W{1'b0}};
        ST_COUNTING: base_s[c] = cnt_r[c];
        default:     base_s[c] = {CNT_W{1'b0}};
      endcase
      // One extra bit so counter + 1 never wraps against an all-ones threshold.
      cnt_inc_s[c] = {1'b0, base_s[c]} + {{CNT_W{1'b0}}, 1'b1};

      if (!chan_en_i[c]) begin
        state_s[c] = ST_STABLE;
        cnt_s[c]   = {CNT_W{1'b0}};
      end else if (!differ_s[c]) begin
        state_s[c] = ST_STABLE;
        cnt_s[c]   = {CNT_W{1'b0}};
      end else if ((threshold_i == {CNT_W{1'b0}}) ||
                   (tick_i && (cnt_inc_s[c] >= thr_ext_s))) begin
        state_s[c] = ST_STABLE;
        cnt_s[c]   = {CNT_W{1'b0}};
        level_s[c] = raw_s[c];
        rise_s[c]  = raw_s[c];
        fall_s[c]  = ~raw_s[c];
      end else if (tick_i) begin
        state_s[c] = ST_COUNTING;
        cnt_s[c]   = cnt_inc_s[c][CNT_W-1:0];
      end else begin
        state_s[c] = ST_COUNTING;
        cnt_s[c]   = base_s[c];
      end
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NCH; c++) begin
        state_r[c] <= ST_STABLE;
        cnt_r[c]   <= {CNT_W{1'b0}};
      end
      level_r <= PULL_VAL ^ INV_MASK;
      rise_r  <= {NCH{1'b0}};
      fall_r  <= {NCH{1'b0}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_r[c] <= state_s[c];
        cnt_r[c]   <= cnt_s[c];
      end
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
    end
  end

  assign level_o = level_r;
  assign rise_o  = rise_r;
  assign fall_o  = fall_r;

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter: directed scenarios followed by a
// randomized phase, all compared against a cycle-level reference model.
module tb_pad_in_filter;

  localparam int         NCH   = 4;
  localparam int         CNT_W = 16;
  localparam int         SYNC  = 2;
  localparam logic [3:0] PULL  = 4'b1111;
  localparam logic [3:0] INV   = 4'b0001;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NCH-1:0]   pad;
  logic             tick;
  logic [CNT_W-1:0] thr;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   level_o, rise_o, fall_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state: pad history stands in for the synchroniser delay,
  // m_cnt counts qualifying ticks seen while raw differs from the level.
  logic [NCH-1:0] m_hist [SYNC];
  logic [NCH-1:0] m_lvl, m_rise, m_fall;
  int             m_cnt [NCH];
  int             rise_seen [NCH];
  int             fall_seen [NCH];

  pad_in_filter #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .PULL_VAL(PULL), .INV_MASK(INV)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .pad_i(pad), .tick_i(tick),
    .threshold_i(thr), .chan_en_i(en),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] raw;
    m_rise = 4'b0000;
    m_fall = 4'b0000;
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = PULL;
      m_lvl = PULL ^ INV;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end else begin
      raw = m_hist[SYNC-1] ^ INV;
      for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad;
      for (int c = 0; c < NCH; c++) begin
        if (!en[c] || raw[c] == m_lvl[c]) begin
          m_cnt[c] = 0;
        end else if (thr == 16'd0 || (tick && (m_cnt[c] + 1 >= int'(thr)))) begin
          m_lvl[c] = raw[c];
          m_cnt[c] = 0;
          if (raw[c]) m_rise[c] = 1'b1;
          else        m_fall[c] = 1'b1;
        end else if (tick) begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < NCH; c++) begin
      rise_seen[c] = 0;
      fall_seen[c] = 0;
    end
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check just after.
  task automatic cycle(input logic r, input logic [3:0] p, input logic t,
                       input logic [15:0] th, input logic [3:0] e);
    @(negedge clk);
    rstn = r; pad = p; tick = t; thr = th; en = e;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("level", 32'(level_o), 32'(m_lvl));
    chk("rise",  32'(rise_o),  32'(m_rise));
    chk("fall",  32'(fall_o),  32'(m_fall));
    for (int c = 0; c < NCH; c++) begin
      rise_seen[c] += int'(rise_o[c]);
      fall_seen[c] += int'(fall_o[c]);
    end
  endtask

  initial begin
    logic [3:0]  rp;
    logic [3:0]  ren;
    logic [15:0] rthr;
    logic [15:0] thr_tab [6];
    int          k_fall;
    int          pre_pulses;

    rstn = 1'b0; pad = 4'b0000; tick = 1'b0; thr = 16'd3; en = 4'b1111;
    thr_tab[0] = 16'd0; thr_tab[1] = 16'd1; thr_tab[2] = 16'd2;
    thr_tab[3] = 16'd3; thr_tab[4] = 16'd4; thr_tab[5] = 16'hFFFF;
    clear_seen();

    // 1: reset with pads low, tick idle
    cycle(1'b0, 4'b0000, 1'b0, 16'd3, 4'b1111);
    cycle(1'b0, 4'b0000, 1'b0, 16'd3, 4'b1111);
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, 4'b0000, 1'b0, 16'd3, 4'b1111);
      chk("t1_level", 32'(level_o), 32'h0000000E);
      chk("t1_pulse", 32'(rise_o | fall_o), 32'h0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b1111, 1'b0, 16'd3, 4'b1111);

    // 2: pad[1] steps low, threshold 3, tick every 4th cycle
    clear_seen();
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'b1101, (cyc % 4 == 0), 16'd3, 4'b1111);
    chk("t2_level1", 32'(level_o[1]), 32'h0);
    chk("t2_fall1",  32'(fall_seen[1]), 32'd1);
    chk("t2_rises",  32'(rise_seen[0] + rise_seen[1] + rise_seen[2] + rise_seen[3]), 32'd0);

    // 3: two-tick glitch on pad[2] is rejected, a sustained low commits
    clear_seen();
    for (int i = 0; i < 8; i++)  cycle(1'b1, 4'b1001, (cyc % 4 == 0), 16'd3, 4'b1111);
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'b1101, (cyc % 4 == 0), 16'd3, 4'b1111);
    chk("t3_glitch_level", 32'(level_o[2]), 32'h1);
    chk("t3_glitch_fall",  32'(fall_seen[2]), 32'd0);
    chk("t3_glitch_cnt",   32'(m_cnt[2]), 32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1001, (cyc % 4 == 0), 16'd3, 4'b1111);
    chk("t3_commit_level", 32'(level_o[2]), 32'h0);
    chk("t3_commit_fall",  32'(fall_seen[2]), 32'd1);

    // 4: bypass, pad[0] toggles every 6 cycles
    clear_seen();
    for (int k = 0; k < 40; k++) begin
      rp = {3'b100, ((k < 36) ? (((k / 6) % 2) == 1) : 1'b1)};
      cycle(1'b1, rp, 1'($urandom_range(0, 1)), 16'd0, 4'b1111);
    end
    chk("t4_rise0",  32'(rise_seen[0]), 32'd3);
    chk("t4_fall0",  32'(fall_seen[0]), 32'd3);
    chk("t4_level0", 32'(level_o[0]), 32'h0);

    // 5: channel 3 disabled while its pad moves, then re-enabled
    clear_seen();
    for (int k = 0; k < 40; k++) begin
      rp = {(((k / 5) % 2) == 1), 3'b001};
      cycle(1'b1, rp, (cyc % 2 == 0), 16'd2, 4'b0111);
    end
    for (int k = 0; k < 6; k++) cycle(1'b1, 4'b0001, (cyc % 2 == 0), 16'd2, 4'b0111);
    chk("t5_frozen_level", 32'(level_o[3]), 32'h1);
    chk("t5_frozen_pulse", 32'(rise_seen[3] + fall_seen[3]), 32'd0);
    for (int k = 0; k < 10; k++) cycle(1'b1, 4'b0001, (cyc % 2 == 0), 16'd2, 4'b1111);
    chk("t5_reen_level", 32'(level_o[3]), 32'h0);
    chk("t5_reen_fall",  32'(fall_seen[3]), 32'd1);

    // 6: reset in the middle of a count
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'b1111, 1'b0, 16'd0, 4'b1111);
    chk("t6_pre_level", 32'(level_o), 32'h0000000E);
    for (int k = 0; k < 10 && m_cnt[1] < 2; k++) cycle(1'b1, 4'b1101, 1'b1, 16'd5, 4'b1111);
    chk("t6_cnt2", 32'(m_cnt[1]), 32'd2);
    cycle(1'b0, 4'b1101, 1'b1, 16'd5, 4'b1111);
    chk("t6_rst_level", 32'(level_o), 32'h0000000E);
    k_fall = -1;
    pre_pulses = 0;
    for (int k = 1; k <= 20 && k_fall < 0; k++) begin
      cycle(1'b1, 4'b1101, 1'b1, 16'd5, 4'b1111);
      if (fall_o[1]) k_fall = k;
      else pre_pulses += int'($countones(rise_o | fall_o));
    end
    chk("t6_commit_edge", 32'(k_fall), 32'(SYNC + 5));
    chk("t6_no_spurious", 32'(pre_pulses), 32'd0);

    // All-ones threshold never commits early; lowering it commits on the next tick
    for (int k = 0; k < 40; k++) cycle(1'b1, 4'b1111, 1'b1, 16'hFFFF, 4'b1111);
    chk("allones_level1", 32'(level_o[1]), 32'h0);
    cycle(1'b1, 4'b1111, 1'b1, 16'd2, 4'b1111);
    chk("lowered_rise1", 32'(rise_o[1]), 32'h1);

    // Randomized phase
    rp = 4'b1111; ren = 4'b1111; rthr = 16'd2;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) rthr = thr_tab[$urandom_range(0, 5)];
      if (k % 20 == 0) begin
        for (int c = 0; c < NCH; c++) ren[c] = ($urandom_range(0, 7) != 0);
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) rp[c] = ~rp[c];
      end
      cycle(($urandom_range(0, 199) != 0), rp, ($urandom_range(0, 2) == 0), rthr, ren);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
